// File: rtl/lda_pkg.sv
// Shared FSM type and width helpers for the Bresenham line engine.
package lda_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  // Extra bits on the error term so it cannot overflow at full-range deltas.
  localparam int ERR_PAD = 2;

  function automatic int cw(input int x_w, input int y_w);
    return (x_w > y_w) ? x_w : y_w;
  endfunction

endpackage

// File: rtl/lda_abs_diff.sv
// Unsigned absolute difference |a-b| with an a>b flag.
module lda_abs_diff #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         a_gt_b_o
);

  assign a_gt_b_o = (a_i > b_i);
  assign diff_o   = a_gt_b_o ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/lda_line_engine.sv
// Bresenham line engine: start handshake in, valid/ready pixel stream out.
// Define LDA_CLIP_EN to drop pixels outside SCREEN_W x SCREEN_H.
module lda_line_engine
  import lda_pkg::*;
#(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  output logic                 o_ready,
  input  logic [X_W-1:0]       i_x0,
  input  logic [X_W-1:0]       i_x1,
  input  logic [Y_W-1:0]       i_y0,
  input  logic [Y_W-1:0]       i_y1,
  input  logic [COL_W-1:0]     i_col,
  output logic                 o_plot,
  input  logic                 i_plot_ready,
  output logic [X_W-1:0]       o_x,
  output logic [Y_W-1:0]       o_y,
  output logic [COL_W-1:0]     o_col,
  output logic                 o_done,
  output logic [X_W+Y_W-1:0]   o_count
);

  localparam int CW = cw(X_W, Y_W);
  localparam int EW = CW + ERR_PAD;
  localparam int NW = X_W + Y_W;

  state_t               state_q;
  logic [X_W-1:0]       x0_q, x1_q;
  logic [Y_W-1:0]       y0_q, y1_q;
  logic [COL_W-1:0]     col_q;
  logic                 steep_q;
  logic [CW-1:0]        maj_q, min_q, end_q, dmaj_q, dmin_q, ystep_q;
  logic signed [EW-1:0] err_q;
  logic [NW-1:0]        count_q;

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  logic           x_gt, y_gt;

  lda_abs_diff #(.W(X_W)) u_dx (.a_i(x0_q), .b_i(x1_q), .diff_o(dx), .a_gt_b_o(x_gt));
  lda_abs_diff #(.W(Y_W)) u_dy (.a_i(y0_q), .b_i(y1_q), .diff_o(dy), .a_gt_b_o(y_gt));

  logic                 steep_d, back_d;
  logic [CW-1:0]        a0, b0, a1, b1;
  logic [CW-1:0]        maj_start_d, min_start_d, end_d, min_end_d, dmaj_d, dmin_d, ystep_d;
  logic signed [EW-1:0] err_init_d;

  // Setup: pick the major axis and walk it in ascending order.
  always_comb begin
    steep_d = CW'(dy) > CW'(dx);
    back_d  = steep_d ? y_gt : x_gt;
    if (steep_d) begin
      a0 = CW'(y0_q); b0 = CW'(x0_q); a1 = CW'(y1_q); b1 = CW'(x1_q);
      dmaj_d = CW'(dy); dmin_d = CW'(dx);
    end else begin
      a0 = CW'(x0_q); b0 = CW'(y0_q); a1 = CW'(x1_q); b1 = CW'(y1_q);
      dmaj_d = CW'(dx); dmin_d = CW'(dy);
    end
    maj_start_d = back_d ? a1 : a0;
    min_start_d = back_d ? b1 : b0;
    end_d       = back_d ? a0 : a1;
    min_end_d   = back_d ? b0 : b1;
    ystep_d     = (min_end_d >= min_start_d) ? CW'(1) : '1;
    err_init_d  = -$signed(EW'(dmaj_d >> 1));
  end

  logic [X_W-1:0]       pix_x;
  logic [Y_W-1:0]       pix_y;
  logic signed [EW-1:0] err_step, err_d;
  logic [CW-1:0]        min_d;
  logic                 visible, advance;

  always_comb begin
    pix_x    = steep_q ? X_W'(min_q) : X_W'(maj_q);
    pix_y    = steep_q ? Y_W'(maj_q) : Y_W'(min_q);
    err_step = err_q + $signed({{ERR_PAD{1'b0}}, dmin_q});
    if (err_step > 0) begin
      min_d = min_q + ystep_q;
      err_d = err_step - $signed({{ERR_PAD{1'b0}}, dmaj_q});
    end else begin
      min_d = min_q;
      err_d = err_step;
    end
`ifdef LDA_CLIP_EN
    visible = (32'(pix_x) < SCREEN_W) && (32'(pix_y) < SCREEN_H);
`else
    visible = 1'b1;
`endif
    // Clipped pixels are skipped without waiting for the sink.
    advance = (state_q == DRAW) && (!visible || i_plot_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      steep_q <= 1'b0;
      maj_q   <= '0;
      min_q   <= '0;
      end_q   <= '0;
      dmaj_q  <= '0;
      dmin_q  <= '0;
      ystep_q <= '0;
      err_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            x0_q    <= i_x0;
            x1_q    <= i_x1;
            y0_q    <= i_y0;
            y1_q    <= i_y1;
            col_q   <= i_col;
            count_q <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          steep_q <= steep_d;
          maj_q   <= maj_start_d;
          min_q   <= min_start_d;
          end_q   <= end_d;
          dmaj_q  <= dmaj_d;
          dmin_q  <= dmin_d;
          ystep_q <= ystep_d;
          err_q   <= err_init_d;
          state_q <= DRAW;
        end
        DRAW: begin
          if (advance) begin
            if (visible) count_q <= count_q + NW'(1);
            // Equality test so a line ending at the top code still terminates.
            if (maj_q == end_q) begin
              state_q <= DONE;
            end else begin
              maj_q <= maj_q + CW'(1);
              min_q <= min_d;
              err_q <= err_d;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_plot  = (state_q == DRAW) && visible;
  assign o_done  = (state_q == DONE);
  assign o_x     = pix_x;
  assign o_y     = pix_y;
  assign o_col   = col_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_lda_line_engine.sv
// Randomised bench for lda_line_engine against a closed-form line model.
// Build with LDA_CLIP_EN defined to exercise the clipping variant.
module tb_lda_line_engine;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int COL_W = 3;
  localparam int SW = 320;
  localparam int SH = 240;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               i_start = 1'b0;
  logic               o_ready;
  logic [X_W-1:0]     i_x0 = '0, i_x1 = '0;
  logic [Y_W-1:0]     i_y0 = '0, i_y1 = '0;
  logic [COL_W-1:0]   i_col = '0;
  logic               o_plot;
  logic               i_plot_ready = 1'b0;
  logic [X_W-1:0]     o_x;
  logic [Y_W-1:0]     o_y;
  logic [COL_W-1:0]   o_col;
  logic               o_done;
  logic [X_W+Y_W-1:0] o_count;

  int checks = 0;
  int errors = 0;
  int exp_x[$];
  int exp_y[$];
  bit exp_first_vis;

  always #5 clk = ~clk;

  lda_line_engine #(.X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .o_ready(o_ready),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1), .i_col(i_col),
    .o_plot(o_plot), .i_plot_ready(i_plot_ready), .o_x(o_x), .o_y(o_y),
    .o_col(o_col), .o_done(o_done), .o_count(o_count)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic bit on_screen(input int x, input int y);
`ifdef LDA_CLIP_EN
    return (x < SW) && (y < SH);
`else
    return (x >= 0) && (y >= 0);
`endif
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Minor offset after i major steps is ceil((i*dmin - dmaj/2)/dmaj), floored at 0.
  task automatic build_model(input int x0, input int y0, input int x1, input int y1);
    int a0, b0, a1, b1, t, dmaj, dmin, s, h, n, m, px, py;
    bit steep;
    exp_x.delete();
    exp_y.delete();
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    if (steep) begin a0 = y0; b0 = x0; a1 = y1; b1 = x1; end
    else       begin a0 = x0; b0 = y0; a1 = x1; b1 = y1; end
    if (a0 > a1) begin
      t = a0; a0 = a1; a1 = t;
      t = b0; b0 = b1; b1 = t;
    end
    dmaj = a1 - a0;
    dmin = iabs(b1 - b0);
    s = (b1 >= b0) ? 1 : -1;
    h = dmaj / 2;
    for (int i = 0; i <= dmaj; i++) begin
      n = i * dmin - h;
      m = (n <= 0) ? 0 : (n + dmaj - 1) / dmaj;
      if (steep) begin px = b0 + s * m; py = a0 + i; end
      else       begin px = a0 + i;     py = b0 + s * m; end
      if (i == 0) exp_first_vis = on_screen(px, py);
      if (on_screen(px, py)) begin
        exp_x.push_back(px);
        exp_y.push_back(py);
      end
    end
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1, input int col,
                          input int mode, input bit noise, input string name);
    int got, cyc, px, py;
    bit done_seen, stall_prev, rdy;
    build_model(x0, y0, x1, y1);
    i_x0 = X_W'(x0); i_y0 = Y_W'(y0); i_x1 = X_W'(x1); i_y1 = Y_W'(y1);
    i_col = COL_W'(col);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (noise) begin
      i_x0 = X_W'($urandom); i_x1 = X_W'($urandom);
      i_y0 = Y_W'($urandom); i_y1 = Y_W'($urandom); i_col = COL_W'($urandom);
    end
    checks++;
    if (o_ready !== 1'b0 || o_plot !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: ready=%b plot=%b, required ready=0 plot=0", name, o_ready, o_plot);
    end
    got = 0; cyc = 0; done_seen = 0; stall_prev = 0; px = 0; py = 0;
    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_plot_ready = rdy;
      if (cyc == 0 && exp_first_vis) begin
        checks++;
        if (o_plot !== 1'b1) begin
          errors++;
          $display("FAIL %s latency: plot=%b two cycles after accept, required 1", name, o_plot);
        end
      end
      if (stall_prev) begin
        checks++;
        if (o_plot !== 1'b1 || o_x !== X_W'(px) || o_y !== Y_W'(py)) begin
          errors++;
          $display("FAIL %s hold: plot=%b (%0d,%0d), required plot=1 (%0d,%0d)", name, o_plot, o_x, o_y, px, py);
        end
      end
      if (o_plot === 1'b1) begin
        checks++;
        if (got >= exp_x.size()) begin
          errors++;
          $display("FAIL %s extra pixel (%0d,%0d), required only %0d pixels", name, o_x, o_y, exp_x.size());
        end else if (o_x !== X_W'(exp_x[got]) || o_y !== Y_W'(exp_y[got]) || o_col !== COL_W'(col)) begin
          errors++;
          $display("FAIL %s pixel %0d: (%0d,%0d) col %0d, required (%0d,%0d) col %0d",
                   name, got, o_x, o_y, o_col, exp_x[got], exp_y[got], col);
        end
        px = int'(o_x); py = int'(o_y);
        if (rdy) got++;
      end
      stall_prev = (o_plot === 1'b1) && !rdy;
      if (o_done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (got != exp_x.size() || o_count !== (X_W+Y_W)'(exp_x.size()) || o_plot !== 1'b0) begin
          errors++;
          $display("FAIL %s done: accepted %0d count %0d plot %b, required %0d pixels count %0d plot 0",
                   name, got, o_count, o_plot, exp_x.size(), exp_x.size());
        end
      end
      i_start = noise && (o_plot === 1'b1);
      cyc++;
    end
    i_start = 1'b0;
    i_plot_ready = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, accepted %0d of %0d", name, cyc, got, exp_x.size());
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after done: done=%b ready=%b, required done=0 ready=1", name, o_done, o_ready);
    end
    $display("line %s (%0d,%0d)->(%0d,%0d) mode %0d pixels %0d count %0d cycles %0d",
             name, x0, y0, x1, y1, mode, got, o_count, cyc);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_plot !== 1'b0 || o_done !== 1'b0 || o_x !== '0 || o_y !== '0 ||
        o_col !== '0 || o_count !== '0) begin
      errors++;
      $display("FAIL reset state: ready=%b plot=%b done=%b x=%0d y=%0d col=%0d count=%0d, required 1,0,0,0,0,0,0",
               o_ready, o_plot, o_done, o_x, o_y, o_col, o_count);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("reset released, ready=%b", o_ready);
  endtask

  task automatic test_directed;
    run_line(0, 0, 4, 2, 5, 0, 1'b0, "shallow");
    run_line(10, 20, 10, 15, 3, 0, 1'b0, "steep_back");
    run_line(0, 0, 12, 5, 6, 0, 1'b1, "ignore_start");
    run_line(3, 3, 3, 3, 7, 0, 1'b1, "single");
  endtask

  task automatic test_stall;
    run_line(0, 0, 7, 7, 2, 1, 1'b0, "stall_diag");
    run_line(20, 3, 2, 9, 1, 2, 1'b0, "stall_rand");
  endtask

  task automatic test_full_range;
    run_line(0, 0, 511, 255, 4, 0, 1'b0, "full_fwd");
    run_line(511, 255, 0, 0, 1, 2, 1'b0, "full_back");
    run_line(0, 255, 511, 0, 6, 0, 1'b0, "full_anti");
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      run_line(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 7)), 2, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_draw;
    int cnt;
    i_x0 = 0; i_y0 = 0; i_x1 = 20; i_y1 = 0; i_col = 3;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_plot_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (o_plot !== 1'b1 || o_x !== 9'd3) begin
      errors++;
      $display("FAIL mid_reset pre: plot=%b x=%0d, required plot=1 x=3", o_plot, o_x);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (o_plot !== 1'b0 || o_ready !== 1'b1 || o_count !== '0 || o_x !== '0) begin
      errors++;
      $display("FAIL mid_reset: plot=%b ready=%b count=%0d x=%0d, required 0,1,0,0", o_plot, o_ready, o_count, o_x);
    end
    @(negedge clk);
    reset = 1'b0;
    i_plot_ready = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_ready !== 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL mid_reset after: %0d cycles with done or not ready, required 0", cnt);
    end
    $display("line mid_reset aborted at pixel 3");
  endtask

`ifdef LDA_CLIP_EN
  task automatic test_clip;
    run_line(318, 0, 322, 0, 5, 0, 1'b0, "clip_edge");
    run_line(400, 250, 410, 250, 2, 1, 1'b0, "clip_all");
    run_line(300, 230, 330, 250, 7, 2, 1'b0, "clip_corner");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_full_range();
`ifdef LDA_CLIP_EN
    test_clip();
`endif
    test_random();
    test_reset_mid_draw();
    run_line(5, 9, 1, 2, 4, 0, 1'b0, "post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
